lc3b_mem_responder: RTL and testbench

Word-organised memory responder for the LC-3b datapath/control pair: the target end of the `mem_read`/`mem_write`/`mem_resp` handshake. It accepts one request at a time, waits a programmable number of cycles, performs the access with byte enables, then pulses `mem_resp` for one cycle. It replaces the simulation-only memory model in the MP testbench and serves as the backing store behind the future cache.

---
 rtl/lc3b_mem_responder_if.sv | 40 ++++
 rtl/lc3b_mem_responder.sv | 166 ++++++++++++++++
 tb/tb_lc3b_mem_responder.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3b_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : lc3b_mem_responder_if
// Description : LC-3b memory handshake bundle (mem_read / mem_write /
//               mem_resp) between an initiator and a memory responder.
//   master : drives mem_read, mem_write, mem_byte_enable, mem_address,
//            mem_wdata; receives mem_resp, mem_rdata
//   slave  : the mirror image, used by the responder
// Revision    : 1.0 - initial release
// ============================================================================
interface lc3b_mem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic        mem_resp;
    logic [15:0] mem_rdata;

    modport master (
        output mem_read,
        output mem_write,
        output mem_byte_enable,
        output mem_address,
        output mem_wdata,
        input  mem_resp,
        input  mem_rdata
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_byte_enable,
        input  mem_address,
        input  mem_wdata,
        output mem_resp,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/lc3b_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : lc3b_mem_responder
// Description : Word-organised memory responder for the LC-3b handshake.
//               Accepts one request at a time, waits LATENCY cycles, performs
//               a byte-enabled read or write, then pulses mem_resp once.
// Ports       : clk  - clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - lc3b_mem_responder_if.slave (request in, resp/rdata out)
// Parameters  : ADDR_W  - word-index width (2^ADDR_W 16-bit words)
//               LATENCY - cycles from acceptance to mem_resp, 1..15
// Revision    : 1.0 - initial release
// ============================================================================
module lc3b_mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    lc3b_mem_responder_if.slave   bus
);

    localparam int         c_DEPTH    = 1 << ADDR_W;
    // WAIT spends LATENCY-1 cycles counting this value down to zero.
    localparam logic [3:0] c_CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [3:0]        r_cnt;

    logic [ADDR_W-1:0] r_idx;
    logic [15:0]       r_wdata;
    logic [1:0]        r_be;
    logic              r_is_wr;

    logic              r_resp;
    logic [15:0]       r_rdata;
    logic [15:0]       r_mem [c_DEPTH];

    logic              w_req;
    logic              w_capture;
    logic              w_commit;
    logic [ADDR_W-1:0] w_acc_idx;
    logic [15:0]       w_acc_wdata;
    logic [1:0]        w_acc_be;
    logic              w_acc_is_wr;
    logic              w_unused;

    assign w_req    = bus.mem_read | bus.mem_write;
    // Address bit 0 and bits above ADDR_W are intentionally discarded.
    assign w_unused = &{1'b0, bus.mem_address};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_req) begin
                    w_state_nxt = (LATENCY == 1) ? c_ST_RESP : c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = c_ST_RESP;
                end
            end
            c_ST_RESP: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_capture   = (r_state == c_ST_IDLE) && w_req;
        // RESP is always followed by IDLE, so a RESP next-state means the
        // edge that enters RESP: that is where the access happens.
        w_commit    = (w_state_nxt == c_ST_RESP);
        // With LATENCY=1 acceptance and access share one edge, so the
        // access must see the request inputs rather than the capture regs.
        w_acc_idx   = r_idx;
        w_acc_wdata = r_wdata;
        w_acc_be    = r_be;
        w_acc_is_wr = r_is_wr;
        if (w_capture) begin
            w_acc_idx   = bus.mem_address[ADDR_W:1];
            w_acc_wdata = bus.mem_wdata;
            w_acc_be    = bus.mem_byte_enable;
            w_acc_is_wr = bus.mem_write;
        end
    end

    // ------------------------------------------------------------------
    // Request capture, latency counter and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_wdata <= 16'h0000;
            r_be    <= 2'b00;
            r_is_wr <= 1'b0;
            r_resp  <= 1'b0;
            r_rdata <= 16'h0000;
        end else begin
            if (w_capture) begin
                r_cnt   <= c_CNT_LOAD;
                r_idx   <= bus.mem_address[ADDR_W:1];
                r_wdata <= bus.mem_wdata;
                r_be    <= bus.mem_byte_enable;
                // Read and write together is treated as a write.
                r_is_wr <= bus.mem_write;
            end else if ((r_state == c_ST_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            r_resp <= w_commit;

            if (w_commit && !w_acc_is_wr) begin
                r_rdata <= r_mem[w_acc_idx];
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage array: never reset, and a reset on the commit edge blocks
    // the write.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && w_commit && w_acc_is_wr) begin
            if (w_acc_be[0]) begin
                r_mem[w_acc_idx][7:0] <= w_acc_wdata[7:0];
            end
            if (w_acc_be[1]) begin
                r_mem[w_acc_idx][15:8] <= w_acc_wdata[15:8];
            end
        end
    end

    assign bus.mem_resp  = r_resp;
    assign bus.mem_rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_lc3b_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_lc3b_mem_responder
// Description : Self-checking bench for lc3b_mem_responder. Three instances
//               (LATENCY 2, 1, 4; ADDR_W 8) share a clock and reset. Each
//               transaction pushes its expected read data to a scoreboard
//               queue that is popped at the response cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lc3b_mem_responder;

    function automatic int lat_of(input int g);
        return (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    endfunction

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [2:0]        tb_rd    = '0;
    logic [2:0]        tb_wr    = '0;
    logic [2:0][1:0]   tb_be    = '0;
    logic [2:0][15:0]  tb_addr  = '0;
    logic [2:0][15:0]  tb_wdata = '0;
    logic [2:0]        tb_resp;
    logic [2:0][15:0]  tb_rdata;

    logic [15:0] model [3][256];
    logic [15:0] last_rd [3];
    logic [15:0] sb_q [$];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        lc3b_mem_responder_if u_bus ();
        assign u_bus.mem_read        = tb_rd[g];
        assign u_bus.mem_write       = tb_wr[g];
        assign u_bus.mem_byte_enable = tb_be[g];
        assign u_bus.mem_address     = tb_addr[g];
        assign u_bus.mem_wdata       = tb_wdata[g];
        assign tb_resp[g]            = u_bus.mem_resp;
        assign tb_rdata[g]           = u_bus.mem_rdata;

        lc3b_mem_responder #(
            .ADDR_W  (8),
            .LATENCY (lat_of(g))
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (u_bus)
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] sb_pop();
        if (sb_q.size() == 0) return 16'hxxxx;
        return sb_q.pop_front();
    endfunction

    // One full transaction on instance sel, started in the current cycle
    // (cycle 0). Checks response cycle, pulse count and read data.
    task automatic run_xact(input int sel, input bit rd, input bit wr,
                            input logic [15:0] addr, input logic [15:0] wdata,
                            input logic [1:0] be, input string name);
        logic [7:0]  idx;
        logic [15:0] got;
        logic [15:0] exp;
        int          first;
        int          pulses;
        idx = addr[8:1];
        if (wr) begin
            if (be[0]) model[sel][idx][7:0]  = wdata[7:0];
            if (be[1]) model[sel][idx][15:8] = wdata[15:8];
        end else begin
            last_rd[sel] = model[sel][idx];
        end
        sb_q.push_back(last_rd[sel]);

        tb_rd[sel]    = rd;
        tb_wr[sel]    = wr;
        tb_addr[sel]  = addr;
        tb_wdata[sel] = wdata;
        tb_be[sel]    = be;
        first  = -1;
        pulses = 0;
        got    = 16'h0000;
        for (int n = 1; n <= lat_of(sel) + 3; n++) begin
            tick();
            if (tb_resp[sel]) begin
                pulses++;
                if (first < 0) begin
                    first = n;
                    got   = tb_rdata[sel];
                end
                tb_rd[sel] = 1'b0;
                tb_wr[sel] = 1'b0;
            end
        end
        tb_rd[sel] = 1'b0;
        tb_wr[sel] = 1'b0;

        checks++;
        if (first !== lat_of(sel)) begin
            failures++;
            $display("FAIL %s resp_cycle: got %0d expected %0d", name, first, lat_of(sel));
        end
        checks++;
        if (pulses !== 1) begin
            failures++;
            $display("FAIL %s resp_pulses: got %0d expected 1", name, pulses);
        end
        exp = sb_pop();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s rdata: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        for (int s = 0; s < 3; s++) begin
            last_rd[s] = 16'h0000;
            checks++;
            if (tb_resp[s] !== 1'b0) begin
                failures++;
                $display("FAIL reset_resp[%0d]: got %b expected 0", s, tb_resp[s]);
            end
            checks++;
            if (tb_rdata[s] !== 16'h0000) begin
                failures++;
                $display("FAIL reset_rdata[%0d]: got %h expected 0000", s, tb_rdata[s]);
            end
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        run_xact(0, 0, 1, 16'h0010, 16'hBEEF, 2'b11, "basic_wr");
        run_xact(0, 1, 0, 16'h0010, 16'h0000, 2'b11, "basic_rd");
    endtask

    task automatic test_byte_lanes();
        run_xact(0, 0, 1, 16'h0020, 16'h1234, 2'b11, "lane_wr11");
        run_xact(0, 0, 1, 16'h0020, 16'hAB00, 2'b10, "lane_wr10");
        run_xact(0, 0, 1, 16'h0020, 16'h00CD, 2'b01, "lane_wr01");
        run_xact(0, 0, 1, 16'h0020, 16'h9999, 2'b00, "lane_wr00");
        run_xact(0, 1, 0, 16'h0020, 16'h0000, 2'b00, "lane_rd");
        checks++;
        if (last_rd[0] !== 16'hABCD) begin
            failures++;
            $display("FAIL lane_model: got %h expected abcd", last_rd[0]);
        end
    endtask

    task automatic test_odd_wrap();
        run_xact(0, 0, 1, 16'h0203, 16'h5555, 2'b11, "wrap_wr");
        run_xact(0, 1, 0, 16'h0002, 16'h0000, 2'b11, "wrap_rd");
    endtask

    task automatic test_back_to_back();
        int          cyc [$];
        logic [15:0] got [$];
        logic [15:0] mid;
        logic [15:0] exp;
        run_xact(1, 0, 1, 16'h0040, 16'h4242, 2'b11, "b2b_wr");
        last_rd[1] = model[1][8'h20];
        sb_q.push_back(last_rd[1]);
        sb_q.push_back(last_rd[1]);
        tb_rd[1]   = 1'b1;
        tb_addr[1] = 16'h0040;
        mid = 16'h0000;
        for (int n = 1; n <= 6; n++) begin
            tick();
            if (tb_resp[1]) begin
                cyc.push_back(n);
                got.push_back(tb_rdata[1]);
            end
            if (n == 2) mid = tb_rdata[1];
            if (n == 3) tb_rd[1] = 1'b0;
        end
        tb_rd[1] = 1'b0;
        checks++;
        if (cyc.size() !== 2) begin
            failures++;
            $display("FAIL b2b_pulses: got %0d expected 2", cyc.size());
        end else begin
            checks++;
            if (cyc[0] !== 1 || cyc[1] !== 3) begin
                failures++;
                $display("FAIL b2b_cycles: got %0d,%0d expected 1,3", cyc[0], cyc[1]);
            end
            for (int k = 0; k < 2; k++) begin
                exp = sb_pop();
                checks++;
                if (got[k] !== exp) begin
                    failures++;
                    $display("FAIL b2b_rdata%0d: got %h expected %h", k, got[k], exp);
                end
            end
        end
        while (sb_q.size() != 0) void'(sb_pop());
        checks++;
        if (mid !== 16'h4242) begin
            failures++;
            $display("FAIL b2b_stable: got %h expected 4242", mid);
        end
    endtask

    task automatic test_mid_reset();
        int pulses;
        run_xact(2, 0, 1, 16'h0060, 16'h0000, 2'b11, "mrst_init");
        tb_wr[2]    = 1'b1;
        tb_addr[2]  = 16'h0060;
        tb_wdata[2] = 16'hFFFF;
        tb_be[2]    = 2'b11;
        pulses = 0;
        for (int n = 1; n <= 8; n++) begin
            tick();
            if (tb_resp[2]) pulses++;
            if (n == 2) begin
                rst      = 1'b1;
                tb_wr[2] = 1'b0;
            end
            if (n == 3) rst = 1'b0;
        end
        for (int s = 0; s < 3; s++) last_rd[s] = 16'h0000;
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL mrst_pulses: got %0d expected 0", pulses);
        end
        run_xact(2, 1, 0, 16'h0060, 16'h0000, 2'b11, "mrst_rd");
    endtask

    task automatic test_rw_both();
        run_xact(0, 1, 0, 16'h0010, 16'h0000, 2'b11, "rw_pre_rd");
        run_xact(0, 1, 1, 16'h0070, 16'h7777, 2'b11, "rw_both");
        run_xact(0, 1, 0, 16'h0070, 16'h0000, 2'b11, "rw_post_rd");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byte_lanes();
        test_odd_wrap();
        test_back_to_back();
        test_mid_reset();
        test_rw_both();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
